if_id_buffer: RTL
=================

Name: if_id_buffer

Overview:
- Fetch-to-decode pipeline buffer. Sits directly downstream of the instruction fetch stage and upstream of decode.
- Captures {pc, instruction} pairs from fetch in a small FIFO with valid/ready handshakes on both sides.
- Supports a branch/jump flush from later stages, inserts NOP bubbles when empty, and counts decode-side stall cycles.

Parameters:
- XLEN, 32, width of pc and instruction.
- DEPTH, 2, number of entries; power of two, range 2..8.
- NOP_INSN, 32'h00000013, instruction presented when the buffer is empty (addi x0,x0,0).
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  fetch presents a valid pc/instruction.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_pc  in  XLEN  pc of the fetched instruction.
- in_instruction  in  XLEN  fetched instruction word.
- flush  in  1  discard all buffered and incoming entries (taken branch/jump).
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  XLEN  pc of the head entry.
- out_pc_plus4  out  XLEN  out_pc + 4, modulo 2^XLEN.
- out_instruction  out  XLEN  instruction of the head entry.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- stall_cycles  out  STALL_CNT_W  saturating count of decode stall cycles.

Behaviour:
- Reset (reset=0, asynchronous): all of the following clear immediately, independent of clk:
  - head/tail pointers and count to 0, so out_valid=0 and in_ready=1;
  - stall_cycles to 0;
  - storage to 0.
- Release of reset takes effect at the next rising edge.
- in_ready = (count != DEPTH). It is combinational from count only; there is no dependence on out_ready, so no pop-then-push bypass when full.
- Push: in_valid && in_ready && !flush. Write {in_pc, in_instruction} at tail; tail increments and wraps modulo DEPTH.
- Pop: out_valid && out_ready && !flush. Head increments and wraps modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: an entry accepted at edge N appears on out_valid after edge N. There is no combinational in->out path.
- out_valid = (count != 0).
- out_pc and out_instruction read the head slot when valid. When count == 0:
  - out_instruction = NOP_INSN;
  - out_pc = 0;
  - out_pc_plus4 = 4.
- flush=1 at an edge:
  - head, tail and count go to 0;
  - any concurrent push is dropped;
  - any concurrent pop is ignored;
  - storage contents are not required to clear.
- The cycle after a flush, out_valid=0 and in_ready=1.
- flush held for multiple cycles keeps the buffer empty.
- stall_cycles: increments by 1 at each edge where out_valid && !out_ready && !flush. It saturates at all-ones and is never reset by flush.
- Full and empty are never ambiguous; count, not pointer equality, is authoritative.
- Reset asserted mid-transfer drops all entries; no partial state survives.

Decomposition:
- Shared package (pipeline_pkg): XLEN, NOP_INSN, and the {pc, instruction} fetch-packet typedef reused by fetch and decode.
- One natural sub-module: sync_fifo (generic DEPTH x width storage plus pointers, count, and flush input). if_id_buffer wraps it with the NOP/pc_plus4 output logic and the stall counter.

Test Plan:
- Reset then single transfer: pulse reset low 10 ns; in_valid=1, pc=0x0, insn=0x00500093 for one cycle, out_ready=1 → out_valid=1 next cycle with out_pc=0x0, out_pc_plus4=0x4, out_instruction=0x00500093; then empty with out_instruction=0x00000013.
- Fill/backpressure: out_ready=0, push pc=0x0 and pc=0x4 → count=2, in_ready=0; a third push (pc=0x8) is not accepted; raise out_ready → pops in order 0x0, 0x4; stall_cycles equals the number of held cycles.
- Streaming: in_valid=1 and out_ready=1 continuously for pcs 0x0..0x1C → outputs appear in order one cycle later, count stays 1, in_ready stays 1, and each pc appears exactly once.
- Flush with concurrent push: buffer holds 0x0, 0x4; assert flush together with in_valid (pc=0x8) → next cycle count=0, out_valid=0; 0x8 never appears on the output.
- Async reset mid-operation: with count=2, drive reset low between edges → count=0, out_valid=0, stall_cycles=0 before the next edge.
- Wrap and saturation: stream 10 entries with DEPTH=2 to wrap pointers several times, checking order; with STALL_CNT_W=4 hold a stall for 20 cycles → stall_cycles=15.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Definitions shared by the fetch, if/id buffer and decode
//               stages. Holds the default datapath width, the bubble
//               instruction and the {pc, instruction} fetch packet.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 : architecturally a no-op, used as a pipeline bubble
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_pkt_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Generic DEPTH x WIDTH synchronous FIFO with a flush input.
//               Occupancy is tracked by an explicit count so that full and
//               empty never rely on pointer equality.
// Revision    : 1.0 - initial release
// Ports       :
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   flush       in   empty the FIFO; concurrent push and pop are ignored
//   push_valid  in   producer offers push_data
//   push_ready  out  space available (depends on count only)
//   push_data   in   WIDTH-bit write data
//   pop_valid   out  head entry valid
//   pop_ready   in   consumer takes the head
//   pop_data    out  head entry (raw slot contents, even when empty)
//   count       out  number of occupied entries
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push;
  logic             pop;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign pop_data   = mem_q[head_q];
  assign count      = count_q;

  assign push = push_valid && push_ready && !flush;
  assign pop  = pop_valid && pop_ready && !flush;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : Fetch-to-decode pipeline buffer. Queues {pc, instruction}
//               pairs, presents a NOP bubble when empty, supports a
//               branch/jump flush and counts decode stall cycles.
// Revision    : 1.0 - initial release
// Ports       :
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-low reset
//   in_valid/ready   fetch-side handshake
//   in_pc            in   pc of the fetched instruction
//   in_instruction   in   fetched instruction word
//   flush            in   discard buffered and incoming entries
//   out_valid/ready  decode-side handshake
//   out_pc           out  head pc (0 when empty)
//   out_pc_plus4     out  out_pc + 4
//   out_instruction  out  head instruction (NOP_INSN when empty)
//   count            out  occupied entries
//   stall_cycles     out  saturating count of decode stall cycles
// ============================================================================
module if_id_buffer
  import pipeline_pkg::*;
#(
  parameter int              XLEN        = pipeline_pkg::XLEN,
  parameter int              DEPTH       = 2,
  parameter logic [XLEN-1:0] NOP_INSN    = XLEN'(pipeline_pkg::NOP_INSN),
  parameter int              STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instruction,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_plus4,
  output logic [XLEN-1:0]          out_instruction,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STALL_CNT_W-1:0]   stall_cycles
);

  logic [2*XLEN-1:0]      head_data;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({in_pc, in_instruction}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_data),
    .count      (count)
  );

  // The raw head slot holds stale data when empty; substitute a bubble.
  assign out_pc          = out_valid ? head_data[2*XLEN-1:XLEN] : '0;
  assign out_instruction = out_valid ? head_data[XLEN-1:0]      : NOP_INSN;
  assign out_pc_plus4    = out_pc + XLEN'(4);

  // Saturating stall counter; deliberately survives flush.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule : if_id_buffer
`default_nettype wire
